// File: rtl/pipelined_control_unit_pkg.sv
// Shared RISC-8 definitions: opcodes, ALU op codes, control bundle and the opcode decoder.
// Used by the registered ID/EX stage and by the older combinational decoder.
package rv8_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_SLB  = 4'hA;
  localparam logic [3:0] OP_SRB  = 4'hB;
  localparam logic [3:0] OP_EQ   = 4'hC;
  localparam logic [3:0] OP_LT   = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic [3:0] aluop;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  reads_rs1;
    logic  reads_rs2;
    logic  reads_rd;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d = '0;
    d.reads_rs1 = (op != OP_NOP);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XNOR, OP_SRA,
      OP_SLB, OP_SRB, OP_EQ, OP_LT, OP_GT: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.aluop    = op;
        d.reads_rs2     = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.aluop    = ALU_ADD;
      end
      OP_LD: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.memread  = 1'b1;
        d.ctrl.memtoreg = 1'b1;
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.aluop    = ALU_ADD;
      end
      OP_ST: begin
        // rd field carries the store-data register
        d.ctrl.memwrite = 1'b1;
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.aluop    = ALU_ADD;
        d.reads_rd      = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.branch = 1'b1;
        d.ctrl.aluop  = ALU_SUB;
        d.reads_rs2   = 1'b1;
      end
      default: d.ctrl = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// IF->ID instruction handshake plus the registered ID/EX control bundle.
// master = instruction source / EX consumer, slave = the control stage.
interface pipelined_control_unit_if #(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 4,
  parameter int ALUOP_W = 4
);
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic               if_ready;
  logic               ex_valid;
  logic               ex_regwrite;
  logic               ex_memread;
  logic               ex_memwrite;
  logic               ex_memtoreg;
  logic               ex_alusrc;
  logic               ex_branch;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [REG_AW-1:0]  ex_rd;
  logic [REG_AW-1:0]  ex_rs1;
  logic [REG_AW-1:0]  ex_rs2;
  logic [REG_AW-1:0]  ex_imm;

  modport master (
    output if_valid, if_instr,
    input  if_ready, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           ex_alusrc, ex_branch, ex_aluop, ex_rd, ex_rs1, ex_rs2, ex_imm
  );

  modport slave (
    input  if_valid, if_instr,
    output if_ready, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           ex_alusrc, ex_branch, ex_aluop, ex_rd, ex_rs1, ex_rs2, ex_imm
  );
endinterface

// File: rtl/pipelined_control_unit_sat_counter.sv
// Saturating event counter: increments on inc unless hold, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !hold && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered ID->EX control stage: decode, one-bubble load-use interlock, flush/hold, debug counters.
// Accepted instruction appears on ex_* one cycle after the if_valid & if_ready handshake.
module pipelined_control_unit
  import rv8_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 4,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_hold,
  input  logic                      flush,
  pipelined_control_unit_if.slave   bus,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } idex_t;

  logic [0:0]        state;
  idex_t             ex_q;
  idex_t             ex_d;
  dec_t              dec;
  logic [3:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              hazard;
  logic              run_hazard;
  logic              stall_take;
  logic              frozen;

  assign op  = bus.if_instr[INSTR_W-1 -: 4];
  assign rd  = bus.if_instr[3*REG_AW-1 -: REG_AW];
  assign rs1 = bus.if_instr[2*REG_AW-1 -: REG_AW];
  assign rs2 = bus.if_instr[REG_AW-1:0];
  assign dec = decode(op);

  assign hazard = ex_q.valid && ex_q.ctrl.memread && bus.if_valid &&
                  ((dec.reads_rs1 && (ex_q.rd == rs1)) ||
                   (dec.reads_rs2 && (ex_q.rd == rs2)) ||
                   (dec.reads_rd  && (ex_q.rd == rd)));

  // In STALL the EX slot is a bubble, so the held instruction can never re-trigger.
  assign run_hazard = (state == ST_RUN) && hazard;
  assign stall_take = !flush && !mem_hold && run_hazard;
  assign frozen     = mem_hold && !flush;

  // Flush still acknowledges IF so the wrong-path instruction is consumed and dropped.
  assign bus.if_ready = !rst && (flush || (!mem_hold && !run_hazard));

  always_comb begin
    ex_d = '0;
    if (bus.if_valid && !run_hazard) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = dec.ctrl;
      ex_d.rd    = rd;
      ex_d.rs1   = rs1;
      ex_d.rs2   = rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      state <= ST_RUN;
    end else if (flush) begin
      ex_q  <= '0;
      state <= ST_RUN;
    end else if (!mem_hold) begin
      ex_q  <= ex_d;
      state <= stall_take ? ST_STALL : ST_RUN;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_regwrite = ex_q.ctrl.regwrite;
  assign bus.ex_memread  = ex_q.ctrl.memread;
  assign bus.ex_memwrite = ex_q.ctrl.memwrite;
  assign bus.ex_memtoreg = ex_q.ctrl.memtoreg;
  assign bus.ex_alusrc   = ex_q.ctrl.alusrc;
  assign bus.ex_branch   = ex_q.ctrl.branch;
  assign bus.ex_aluop    = ALUOP_W'(ex_q.ctrl.aluop);
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_imm      = ex_q.rs2;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_take),
    .hold (frozen),
    .cnt  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (flush),
    .hold (frozen),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed stimulus with a scoreboard queue; a monitor pops and compares each EX-slot load.
`timescale 1ns/1ps
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_hold;
  logic        flush;
  logic        flush2;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [1:0]  stall_cnt2;
  logic [1:0]  flush_cnt2;

  int checks = 0;
  int errors = 0;
  logic [25:0] sb_q[$];
  logic [25:0] last_exp = '0;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(.INSTR_W(16), .REG_AW(4), .ALUOP_W(4)) bus1 ();
  pipelined_control_unit_if #(.INSTR_W(16), .REG_AW(4), .ALUOP_W(4)) bus2 ();

  pipelined_control_unit #(.INSTR_W(16), .REG_AW(4), .ALUOP_W(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_hold  (mem_hold),
    .flush     (flush),
    .bus       (bus1),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  pipelined_control_unit #(.INSTR_W(16), .REG_AW(4), .ALUOP_W(4), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .mem_hold  (1'b0),
    .flush     (flush2),
    .bus       (bus2),
    .stall_cnt (stall_cnt2),
    .flush_cnt (flush_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {regwrite,memread,memwrite,memtoreg,alusrc,branch}, aluop, rd, rs1, rs2 (imm mirrors rs2)
  function automatic logic [25:0] exp_ex(input logic [5:0] c, input logic [3:0] a,
                                         input logic [3:0] rd, input logic [3:0] rs1,
                                         input logic [3:0] rs2);
    return {c, a, rd, rs1, rs2, rs2};
  endfunction

  function automatic logic [25:0] snap();
    return {bus1.ex_regwrite, bus1.ex_memread, bus1.ex_memwrite, bus1.ex_memtoreg,
            bus1.ex_alusrc, bus1.ex_branch, bus1.ex_aluop, bus1.ex_rd, bus1.ex_rs1,
            bus1.ex_rs2, bus1.ex_imm};
  endfunction

  initial begin : monitor
    logic hold_s;
    logic rst_s;
    logic [25:0] e;
    forever begin
      @(posedge clk);
      hold_s = mem_hold & ~flush;
      rst_s  = rst;
      @(negedge clk);
      if (!rst_s) begin
        if (bus1.ex_valid) begin
          if (hold_s) begin
            chk("hold_frozen", 32'(snap()), 32'(last_exp));
          end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%0h required=no valid slot at %0t", snap(), $time);
          end else begin
            e = sb_q.pop_front();
            chk("sb_ex", 32'(snap()), 32'(e));
            last_exp = e;
          end
        end else begin
          chk("bubble_zero", 32'(snap()), 32'h0);
        end
      end
    end
  end

  task automatic send(input string name, input logic [15:0] ins, input logic [25:0] e,
                      input int exp_stalls);
    int  st = 0;
    bit  done = 0;
    logic rdy;
    bus1.if_valid = 1'b1;
    bus1.if_instr = ins;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      rdy = bus1.if_ready;
      if (rdy && !flush) sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (rdy) done = 1;
      else st++;
    end
    bus1.if_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=not accepted required=accepted within 8 cycles", name);
    end else begin
      chk({name, "_latency"}, 32'(bus1.ex_valid), 32'h1);
      chk({name, "_stalls"}, 32'(st), 32'(exp_stalls));
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    mem_hold = 1'b0;
    flush = 1'b0;
    flush2 = 1'b0;
    bus1.if_valid = 1'b1;
    bus1.if_instr = 16'h0123;
    bus2.if_valid = 1'b0;
    bus2.if_instr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ready", 32'(bus1.if_ready), 32'h0);
    chk("rst_ex_valid", 32'(bus1.ex_valid), 32'h0);
    chk("rst_ex_fields", 32'(snap()), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    rst = 1'b0;
    bus1.if_valid = 1'b0;

    send("add", 16'h0123, exp_ex(6'b100000, 4'h0, 4'h1, 4'h2, 4'h3), 0);
    send("sub", 16'h1456, exp_ex(6'b100000, 4'h1, 4'h4, 4'h5, 4'h6), 0);
    send("nop", 16'hF2A5, exp_ex(6'b000000, 4'h0, 4'h2, 4'hA, 4'h5), 0);
    send("beq", 16'h8123, exp_ex(6'b000001, 4'h1, 4'h1, 4'h2, 4'h3), 0);
    send("xnor", 16'h7ABC, exp_ex(6'b100000, 4'h7, 4'hA, 4'hB, 4'hC), 0);

    send("ld_a", 16'h5230, exp_ex(6'b110110, 4'h0, 4'h2, 4'h3, 4'h0), 0);
    send("add_dep", 16'h0421, exp_ex(6'b100000, 4'h0, 4'h4, 4'h2, 4'h1), 1);
    chk("stall_cnt_1", 32'(stall_cnt), 32'h1);
    send("ld_b", 16'h5230, exp_ex(6'b110110, 4'h0, 4'h2, 4'h3, 4'h0), 0);
    send("st_dep", 16'h6215, exp_ex(6'b001010, 4'h0, 4'h2, 4'h1, 4'h5), 1);
    send("ld_c", 16'h5230, exp_ex(6'b110110, 4'h0, 4'h2, 4'h3, 4'h0), 0);
    send("addi_indep", 16'h4531, exp_ex(6'b100010, 4'h0, 4'h5, 4'h3, 4'h1), 0);
    send("ld_d", 16'h5230, exp_ex(6'b110110, 4'h0, 4'h2, 4'h3, 4'h0), 0);
    send("ld_imm_r2", 16'h5732, exp_ex(6'b110110, 4'h0, 4'h7, 4'h3, 4'h2), 0);
    send("addi_dep", 16'h4172, exp_ex(6'b100010, 4'h0, 4'h1, 4'h7, 4'h2), 1);
    chk("stall_cnt_3", 32'(stall_cnt), 32'h3);
    chk("flush_cnt_0", 32'(flush_cnt), 32'h0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send("ld_f", 16'h5230, exp_ex(6'b110110, 4'h0, 4'h2, 4'h3, 4'h0), 0);
    bus1.if_valid = 1'b1;
    bus1.if_instr = 16'h0421;
    @(negedge clk);
    chk("stall_if_ready", 32'(bus1.if_ready), 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_if_ready", 32'(bus1.if_ready), 32'h1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus1.if_valid = 1'b0;
    chk("flush_ex_valid", 32'(bus1.ex_valid), 32'h0);
    chk("flush_cnt_1", 32'(flush_cnt), 32'h1);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'h1);

    send("add_h", 16'h0123, exp_ex(6'b100000, 4'h0, 4'h1, 4'h2, 4'h3), 0);
    mem_hold = 1'b1;
    bus1.if_valid = 1'b1;
    bus1.if_instr = 16'h1456;
    repeat (3) begin
      @(negedge clk);
      chk("hold_if_ready", 32'(bus1.if_ready), 32'h0);
      chk("hold_ex_valid", 32'(bus1.ex_valid), 32'h1);
      @(posedge clk);
      #1;
    end
    mem_hold = 1'b0;
    send("sub_h", 16'h1456, exp_ex(6'b100000, 4'h1, 4'h4, 4'h5, 4'h6), 0);
    chk("hold_flush_cnt", 32'(flush_cnt), 32'h1);

    flush2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_flush_2", 32'(flush_cnt2), 32'h2);
    repeat (3) @(posedge clk);
    #1;
    flush2 = 1'b0;
    chk("sat_flush_3", 32'(flush_cnt2), 32'h3);
    chk("sat_stall_0", 32'(stall_cnt2), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
